// File: rtl/pipe_stage_pkg.sv
// Pipeline definitions shared by the elastic stage: state encodings.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/flopenr.sv
// Enabled flip-flop with asynchronous active-high reset to a parameterised value.
module flopenr #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline register: main + skid entry, valid/ready on both sides,
// synchronous flush. in_ready/out_valid/out_data all come straight from flops.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output state_t           o_dbg_state
);

    // Handshake: a transfer happens on a side when valid and ready are both
    // high at the rising edge; valid must not wait on ready.
    state_t           r_state;
    state_t           w_state_next;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_main_en;
    logic             w_main_from_skid;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_skid_q;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Flags are registered from the next state so they never decode the illegal code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next != ST_EMPTY);
            r_in_ready  <= (w_state_next != ST_FULL);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) w_state_next = ST_BUSY;
                ST_BUSY: begin
                    if (w_push && !w_pop)      w_state_next = ST_FULL;
                    else if (!w_push && w_pop) w_state_next = ST_EMPTY;
                end
                ST_FULL:  if (w_pop) w_state_next = ST_BUSY;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Flush freezes both data registers; only the state is cleared.
    always_comb begin
        w_main_en        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_en        = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_main_en = w_push;
                ST_BUSY: begin
                    w_main_en = w_push & w_pop;
                    w_skid_en = w_push & ~w_pop;
                end
                ST_FULL: begin
                    w_main_en        = w_pop;
                    w_main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

    flopenr #(.WIDTH(WIDTH), .RESET_VALUE(RESET_DATA)) u_main (
        .i_clock (clock),
        .i_reset (reset),
        .i_en    (w_main_en),
        .i_d     (w_main_d),
        .o_q     (out_data)
    );

    flopenr #(.WIDTH(WIDTH), .RESET_VALUE(RESET_DATA)) u_skid (
        .i_clock (clock),
        .i_reset (reset),
        .i_en    (w_skid_en),
        .i_d     (in_data),
        .o_q     (w_skid_q)
    );

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed + random bench for pipe_stage with a queue-based scoreboard,
// exercising WIDTH=32, 64 (non-zero reset data) and 1 side by side.
module tb_pipe_stage;
    import pipe_stage_pkg::*;

    localparam logic [63:0] RST64 = 64'hDEAD_BEEF_0000_0001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [63:0] in_data64;
    logic [0:0]  in_data1;

    logic        in_ready, out_valid, in_ready64, out_valid64, in_ready1, out_valid1;
    logic [31:0] out_data;
    logic [63:0] out_data64;
    logic [0:0]  out_data1;
    state_t      dbg_state, dbg_state64, dbg_state1;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    assign in_data64 = {~in_data, in_data};
    assign in_data1  = in_data[0];

    always #5 clock = ~clock;

    pipe_stage #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .o_dbg_state(dbg_state)
    );

    pipe_stage #(.WIDTH(64), .RESET_DATA(RST64)) dut64 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
        .o_dbg_state(dbg_state64)
    );

    pipe_stage #(.WIDTH(1), .RESET_DATA(1'b1)) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .o_dbg_state(dbg_state1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check flags against the queue model, score handshakes, advance.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
        logic   push_now, pop_now;
        state_t exp_st;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        exp_st = (exp_q.size() == 0) ? ST_EMPTY : (exp_q.size() == 1) ? ST_BUSY : ST_FULL;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
        chk("state", {62'd0, dbg_state}, {62'd0, exp_st});
        chk("flags64", {62'd0, in_ready64, out_valid64}, {62'd0, in_ready, out_valid});
        chk("flags1", {62'd0, in_ready1, out_valid1}, {62'd0, in_ready, out_valid});
        push_now = v && (exp_q.size() < 2);
        pop_now  = r && (exp_q.size() > 0);
        if (pop_now) begin
            chk("pop_data", {32'd0, out_data}, {32'd0, exp_q[0]});
            chk("pop_data64", out_data64, {~exp_q[0], exp_q[0]});
            chk("pop_data1", {63'd0, out_data1}, {63'd0, exp_q[0][0]});
            void'(exp_q.pop_front());
        end
        if (push_now && !f) exp_q.push_back(d);
        if (f) exp_q.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_data64", out_data64, RST64);
        chk("rst_out_data1", {63'd0, out_data1}, 64'd1);
        chk("rst_state", {62'd0, dbg_state}, {62'd0, ST_EMPTY});

        // Single push, visible right after the edge.
        cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        chk("first_valid", {63'd0, out_valid}, 64'd1);
        chk("first_data", {32'd0, out_data}, 64'hA5A5_A5A5);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Streaming with out_ready held high.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, i, 1'b1, 1'b0);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
        end
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Backpressure into FULL, then drain.
        cyc(1'b1, 32'd7, 1'b0, 1'b0);
        cyc(1'b1, 32'd8, 1'b0, 1'b0);
        chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        cyc(1'b1, 32'd99, 1'b0, 1'b0);
        chk("bp_hold_data", {32'd0, out_data}, 64'd7);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        chk("bp_second_data", {32'd0, out_data}, 64'd8);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush in FULL with push of 9 and pop of 7.
        cyc(1'b1, 32'd7, 1'b0, 1'b0);
        cyc(1'b1, 32'd8, 1'b0, 1'b0);
        cyc(1'b1, 32'd9, 1'b1, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);

        // Flush in BUSY discards an accepted push.
        cyc(1'b1, 32'd5, 1'b0, 1'b0);
        cyc(1'b1, 32'd6, 1'b0, 1'b1);
        chk("flushb_out_valid", {63'd0, out_valid}, 64'd0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0);
        chk("after_flush_data", {32'd0, out_data}, 64'h22);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges while FULL.
        cyc(1'b1, 32'h31, 1'b0, 1'b0);
        cyc(1'b1, 32'h32, 1'b0, 1'b0);
        idle();
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_data64", out_data64, RST64);
        exp_q.delete();
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        cyc(1'b1, 32'h11, 1'b0, 1'b0);
        chk("post_rst_data", {32'd0, out_data}, 64'h11);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Random valid/ready/flush traffic.
        for (int c = 0; c < 10000; c++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 63) == 0));
        end
        for (int c = 0; c < 4; c++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("final_empty", {63'd0, out_valid}, 64'd0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline register with valid/ready handshake, skid storage and synchronous flush. It is the next generation of the plain enabled flip-flop. It sits between CPU pipeline stages (fetch/decode/execute) and between the core and memory-mapped peripherals. It sustains one transfer per cycle with fully registered outputs, so it never forms a combinational path between the upstream and downstream ready signals.

## Interface
- WIDTH, 32, payload width in bits (>= 1)
- RESET_DATA, 0, value loaded into both data registers on reset

- clock  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous clear of all held entries
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept (registered)
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry (registered)
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  head entry (registered)

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated at the rising edge.
- Storage: main register drives out_data; skid register holds a second entry.
- States and flags:
  - EMPTY: out_valid=0, in_ready=1
  - BUSY: out_valid=1, in_ready=1
  - FULL: out_valid=1, in_ready=0
- EMPTY:
  - push: main<=in_data, go to BUSY
  - otherwise stay in EMPTY
- BUSY:
  - push & pop: main<=in_data, stay in BUSY
  - push only: skid<=in_data, go to FULL
  - pop only: go to EMPTY
  - neither: hold
- FULL:
  - pop: main<=skid, go to BUSY
  - otherwise hold. Push is impossible because in_ready=0.
- Ordering is strictly FIFO. No entry is dropped or duplicated except on flush.
- flush has priority over push and pop. Next state is EMPTY and in_ready=1.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle completes normally, since the consumer saw valid data.
  - Data registers keep their contents; only the state is cleared.
- out_data is stable while out_valid=1 and out_ready=0. Upstream must keep in_data stable while in_valid=1 and in_ready=0; the stage does not check this.
- in_valid asserted while in_ready=0 has no effect.

## Timing
- Reset values: state EMPTY, out_valid=0, in_ready=1, out_data=RESET_DATA, skid=RESET_DATA.
- Reset asserted mid-operation clears everything immediately (asynchronously) and drops all held entries.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N.
- Throughput: 1 entry per cycle when out_ready is held at 1.
- in_ready falls the cycle after the skid register fills. It rises the cycle after the first pop from FULL.
- in_ready, out_valid and out_data come only from flops, with no combinational input-to-output path.

## Structure
- Shared constants file (pipeline definitions) holds the 2-bit state encodings: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10. 2'b11 is illegal and recovers to EMPTY.
- Data registers are instances of the existing flopenr generic.
  - They take WIDTH from pipe_stage.
  - Enables come from the control logic.
  - Reset data other than 0 is handled by a flopenr variant with a reset-value parameter.
- Control logic is a single FSM in pipe_stage. No further sub-modules.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, out_data=0. Push 0xA5A5A5A5 → out_valid=1, out_data=0xA5A5A5A5 the next cycle.
- Streaming: push 1,2,3,…,16 back-to-back with out_ready=1 → outputs 1..16 in order, one per cycle, in_ready never 0.
- Backpressure: out_ready=0, push 7 then 8 → in_ready=0 after the second push. Raise out_ready → pops 7 then 8, and in_ready returns to 1 one cycle after 7 is popped.
- Flush in FULL with a simultaneous push of 9 and pop of 7 → consumer gets 7; 8 and 9 are discarded; next cycle out_valid=0, in_ready=1.
- Asynchronous reset mid-stream, asserted between edges while FULL → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; first post-reset push of 0x11 → out_data=0x11.
- WIDTH=1 and WIDTH=64 builds, plus a random valid/ready scoreboard run of 10k cycles → no loss, no duplication, order preserved.
